rsc_enc_src_adapter: RTL

Parametrised source adapter in front of the RSC duobit encoder. It accepts a word stream of `pDAT_W` bits with valid/ready handshake and per-frame runtime code settings, and serialises each word into duobits. It enforces the configured frame length `N` by zero-padding short frames and truncating long ones, then presents an encoder-ready duobit stream with frame markers and held per-frame configuration. It replaces fixed-configuration wrappers when code, permutation type and length must change frame by frame.

---
 rtl/rsc_enc_src_adapter.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/rsc_enc_src_adapter.sv
// Source adapter in front of the RSC duobit encoder.
// Accepts a valid/ready word stream with per-frame code settings and serialises each word into
// duobits (LSB pair first). Frames are forced to the latched length N: short frames are
// zero-padded, long frames are truncated and the excess words are dropped.
//
// Ports:
//   iclk, ireset, iclkena      clock, async active-low reset, clock enable (0 freezes everything)
//   isop, ieop, ival, idat     input word stream with frame markers
//   itag, icode, iptype, iN    per-frame settings, sampled with the isop word
//   ordy                       word accepted on an edge where ival & ordy & iclkena
//   iencrdy                    encoder can start a new frame (sampled only while waiting)
//   obusy                      adapter is inside a frame
//   osop, oeop, oval, odat     duobit stream towards the encoder
//   otag, ocode, optype, oN    latched per-frame settings
//   oerr_*                     one-cycle error pulses (short, long, bad config, sync)
module rsc_enc_src_adapter #(
  parameter int unsigned pTAG_W = 8,
  parameter int unsigned pDAT_W = 8,
  parameter int unsigned pN_MAX = 4096,
  parameter int unsigned pN_W   = $clog2(pN_MAX + 1)
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  logic              isop,
  input  logic              ieop,
  input  logic              ival,
  input  logic [pDAT_W-1:0] idat,
  input  logic [pTAG_W-1:0] itag,
  input  logic [3:0]        icode,
  input  logic [5:0]        iptype,
  input  logic [pN_W-1:0]   iN,
  output logic              ordy,
  input  logic              iencrdy,
  output logic              obusy,
  output logic              osop,
  output logic              oeop,
  output logic              oval,
  output logic [1:0]        odat,
  output logic [pTAG_W-1:0] otag,
  output logic [3:0]        ocode,
  output logic [5:0]        optype,
  output logic [pN_W-1:0]   oN,
  output logic              oerr_short,
  output logic              oerr_long,
  output logic              oerr_cfg,
  output logic              oerr_sync
);

  localparam int unsigned     NDUO     = pDAT_W / 2;
  localparam int unsigned     IDX_W    = (NDUO > 1) ? $clog2(NDUO) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDUO - 1);
  // Only meaningful when NDUO > 1; with a single duobit per word every index is the last one.
  localparam logic [IDX_W-1:0] IDX_PRE  = IDX_W'(NDUO - 2);
  localparam logic            ONE_DUO  = (NDUO == 1);

  typedef enum logic [2:0] {StIdle, StWaitEnc, StRun, StPad, StDrop} state_t;

  state_t             state;
  logic [pDAT_W-1:0]  wreg;     // held word, shifted right as duobits leave
  logic [IDX_W-1:0]   idx;      // index of the duobit currently at wreg[1:0]
  logic               wvalid;   // word register holds unsent duobits
  logic               weop;     // held word carried ieop
  logic [pN_W-1:0]    cnt;      // duobits emitted in this frame

  logic accept, last_duo, at_end, cfg_bad;

  assign accept   = ival & ordy;
  assign last_duo = (idx == IDX_LAST);
  assign at_end   = (cnt == oN - pN_W'(1));
  assign cfg_bad  = (iN == '0) || (iN > pN_W'(pN_MAX));

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      state      <= StIdle;
      wreg       <= '0;
      idx        <= '0;
      wvalid     <= 1'b0;
      weop       <= 1'b0;
      cnt        <= '0;
      ordy       <= 1'b0;
      obusy      <= 1'b0;
      osop       <= 1'b0;
      oeop       <= 1'b0;
      oval       <= 1'b0;
      odat       <= '0;
      otag       <= '0;
      ocode      <= '0;
      optype     <= '0;
      oN         <= '0;
      oerr_short <= 1'b0;
      oerr_long  <= 1'b0;
      oerr_cfg   <= 1'b0;
      oerr_sync  <= 1'b0;
    end else if (iclkena) begin
      // Stream outputs and error flags are single-cycle unless re-asserted below.
      osop       <= 1'b0;
      oeop       <= 1'b0;
      oval       <= 1'b0;
      odat       <= '0;
      oerr_short <= 1'b0;
      oerr_long  <= 1'b0;
      oerr_cfg   <= 1'b0;
      oerr_sync  <= 1'b0;

      unique case (state)
        StIdle: begin
          ordy <= 1'b1;
          if (accept) begin
            if (!isop) begin
              oerr_sync <= 1'b1;
            end else begin
              otag   <= itag;
              ocode  <= icode;
              optype <= iptype;
              oN     <= iN;
              wreg   <= idat;
              idx    <= '0;
              weop   <= ieop;
              cnt    <= '0;
              if (cfg_bad) begin
                oerr_cfg <= 1'b1;
                if (!ieop) begin
                  state <= StDrop;
                  obusy <= 1'b1;
                end
              end else begin
                wvalid <= 1'b1;
                state  <= StWaitEnc;
                obusy  <= 1'b1;
                ordy   <= 1'b0;
              end
            end
          end
        end

        StWaitEnc: begin
          if (iencrdy) begin
            state <= StRun;
            ordy  <= ONE_DUO & ~weop;
          end
        end

        StRun: begin
          if (wvalid) begin
            oval <= 1'b1;
            odat <= wreg[1:0];
            osop <= (cnt == '0);
            oeop <= at_end;
            cnt  <= cnt + pN_W'(1);
            wreg <= wreg >> 2;
            idx  <= idx + IDX_W'(1);
          end

          if (wvalid && at_end) begin
            // Frame length reached: anything still held or arriving is excess.
            wvalid <= 1'b0;
            ordy   <= 1'b1;
            if (!(last_duo && weop)) oerr_long <= 1'b1;
            // An ieop already held or accepted right now closes the source frame.
            if (weop || (accept && ieop)) begin
              state <= StIdle;
              obusy <= 1'b0;
            end else begin
              state <= StDrop;
            end
          end else if (wvalid && !last_duo) begin
            // Raise ready one cycle ahead so the next word lands on the last-duobit edge.
            ordy <= (idx == IDX_PRE) & ~weop;
          end else if (wvalid && weop) begin
            wvalid <= 1'b0;
            ordy   <= 1'b0;
            state  <= StPad;
          end else if (accept) begin
            wreg      <= idat;
            idx       <= '0;
            weop      <= ieop;
            wvalid    <= 1'b1;
            oerr_sync <= isop;
            ordy      <= ONE_DUO & ~ieop;
          end else begin
            wvalid <= 1'b0;
            ordy   <= 1'b1;
          end
        end

        StPad: begin
          oval <= 1'b1;
          oeop <= at_end;
          cnt  <= cnt + pN_W'(1);
          ordy <= 1'b0;
          if (at_end) begin
            oerr_short <= 1'b1;
            state      <= StIdle;
            obusy      <= 1'b0;
            ordy       <= 1'b1;
          end
        end

        StDrop: begin
          ordy <= 1'b1;
          if (accept && ieop) begin
            state <= StIdle;
            obusy <= 1'b0;
          end
        end

        default: begin
          state <= StIdle;
          obusy <= 1'b0;
          ordy  <= 1'b1;
        end
      endcase
    end
  end

endmodule
